// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared size codes, FSM states and alignment helper
// Contents: SIZE_* access-size codes, state_t FSM encoding, is_misaligned().
package mem_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Size code 11 has no meaning, so it is reported the same way as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_byte_lane_merge.sv
// rtl/mem_responder_byte_lane_merge.sv - little-endian lane insert/extract for sub-word access
// Ports:
//   word    in  32  source word (array word or the fetched copy)
//   addr_lo in   2  byte offset within the word
//   size    in   2  access size code
//   wdata   in  32  right-aligned store data
//   merged  out 32  word with the selected lanes replaced by wdata
//   lane    out 32  selected lanes of word, right-aligned and zero-extended
module byte_lane_merge
  import mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] lane
);

  always_comb begin
    merged = word;
    lane   = '0;
    case (size)
      SIZE_BYTE: begin
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        lane[7:0]                      = word[{addr_lo, 3'b000} +: 8];
      end
      SIZE_HALF: begin
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        lane[15:0]                          = word[{addr_lo[1], 4'b0000} +: 16];
      end
      SIZE_WORD: begin
        merged = wdata;
        lane   = word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - req/ack memory responder with sub-word read-modify-write and error reporting
// Ports:
//   clk    in   1  clock, rising edge
//   reset  in   1  asynchronous active-low reset
//   req    in   1  request level, held with addr/wr/size/wdata until ack
//   wr     in   1  1 = write, 0 = read
//   size   in   2  00 byte, 01 half, 10 word, 11 error
//   addr   in  32  byte address
//   wdata  in  32  right-aligned store data
//   ack    out  1  one-cycle completion pulse
//   rdata  out 32  right-aligned zero-extended load data, held until next completion
//   err    out  1  misaligned or out-of-range, valid with ack
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       mem [DEPTH];

  logic        req_err;
  logic [31:0] mem_word;
  logic [31:0] lane_src;
  logic [31:0] merged;
  logic [31:0] lane;

  // Upper address bits beyond the array must be zero: there is no wrap-around.
  assign req_err  = (addr[31:ADDR_W] != '0) || is_misaligned(size, addr[1:0]);
  assign mem_word = mem[addr_q[ADDR_W-1:2]];

  // Loads extract straight from the array on the FETCH->RESP edge; stores
  // merge into the copy captured in FETCH while in COMMIT.
  assign lane_src = (state_q == FETCH) ? mem_word : word_q;

  byte_lane_merge u_merge (
    .word    (lane_src),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .wdata   (wdata_q),
    .merged  (merged),
    .lane    (lane)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_err)                      state_d = RESP;
          else if (wr && size == SIZE_WORD) state_d = COMMIT;
          else                              state_d = FETCH;
        end
      end
      FETCH:   state_d = wr_q ? COMMIT : RESP;
      COMMIT:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      wdata_q <= '0;
      word_q  <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        addr_q  <= addr[ADDR_W-1:0];
        wr_q    <= wr;
        size_q  <= size;
        wdata_q <= wdata;
      end
      if (state_q == FETCH) begin
        word_q <= mem_word;
      end
      ack <= (state_d == RESP);
      if (state_d == RESP) begin
        // RESP is entered from IDLE only on an error.
        err   <= (state_q == IDLE);
        rdata <= (state_q == FETCH && !wr_q) ? lane : '0;
      end else if (state_d == IDLE) begin
        err <= 1'b0;
      end
    end
  end

  // Async reset pulls state_q out of COMMIT at once, so a reset before the
  // commit edge leaves the word untouched.
  always_ff @(posedge clk) begin
    if (state_q == COMMIT) begin
      mem[addr_q[ADDR_W-1:2]] <= merged;
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle CPU's data/instruction memory port. It accepts byte, halfword and word read/write requests over a req/ack handshake, stores data in an internal word-wide array, and performs read-modify-write for sub-word stores. It sits at the memory end of the port that the CPU datapath drives through its address mux and load/store control. It replaces a fixed-latency RAM with one that reports misaligned and out-of-range accesses, so the CPU can raise an exception.

## Interface
Parameters:
- ADDR_W, 8, byte-address width. The array holds 2^(ADDR_W-2) 32-bit words.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  request level; the initiator holds it with addr/wr/size/wdata stable until ack
- wr  in  1  1 = write, 0 = read
- size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as misaligned (err)
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ack  out  1  one-cycle completion pulse
- rdata  out  32  load data, right-aligned and zero-extended; valid while ack=1, held until the next completion
- err  out  1  valid with ack; 1 = misaligned or out of range, no array access performed

## Operation
- Byte order is little-endian: byte k of a word occupies bits [8k+7:8k]. The word index is addr[ADDR_W-1:2].
- Error check, applied in IDLE to the sampled request:
  - addr[31:ADDR_W] is nonzero.
  - size=01 with addr[0]=1.
  - size=10 with addr[1:0]!=0.
  - size=11.
- States: IDLE, FETCH, COMMIT, RESP.
- IDLE: when req=1, register addr, wr, size and wdata. Then go to:
  - RESP with err=1 if the error check fails;
  - COMMIT if this is a word write;
  - FETCH otherwise.
- FETCH: register the addressed word into word_q. Go to RESP for a read, or COMMIT for a sub-word write.
- COMMIT: write to the array. A word write stores wdata. A sub-word write stores word_q with the selected lanes replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
- RESP: ack=1. Then go to IDLE.
  - rdata is loaded on entry to RESP: the extracted lane zero-extended for a read, 0 for a write or error.
  - err is loaded on entry to RESP and cleared on entry to IDLE.
- req is ignored outside IDLE. If req is still high in the cycle after ack, a new transaction starts, so back-to-back requests are legal.
- Array contents are not reset. Reads of never-written words return X in simulation.

## Timing
- Latency is measured from the cycle in which req is sampled in IDLE (cycle 0) to the cycle in which ack is high:
  - error: 1;
  - read (any size): 2;
  - word write: 2;
  - byte or halfword write: 3.
- A write is visible to a read that starts in the cycle after its ack.
- Reset values: ack=0, err=0, rdata=0, state=IDLE.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and no ack is produced.
  - If reset asserts before the COMMIT edge, the array word is unchanged.
  - A COMMIT that completed before reset remains in the array.
- Simultaneous events: req rising in the same cycle that RESP is active is not sampled; it is sampled in the next (IDLE) cycle.
- Address wrap-around does not exist. Any address at or above 2^ADDR_W errors.

## Structure
- Package mem_responder_pkg holds:
  - SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - state encodings IDLE=2'd0, FETCH=2'd1, COMMIT=2'd2, RESP=2'd3.
- Sub-module byte_lane_merge is combinational: inputs word, addr[1:0], size, wdata; outputs merged word and extracted, zero-extended lane. It is shared by the load and store paths.
- The top level contains the FSM, request registers, word_q, the array and the output registers.

## Test plan
- Word store then load, all at ADDR_W=8:
  - stimulus: sw 0xDEADBEEF to 0x10, then lw 0x10;
  - required: write ack 2 cycles after req, err=0; read ack 2 cycles after req with rdata=0xDEADBEEF.
- Byte merge:
  - stimulus: after the word store above, sb 0x55 to 0x11, then lw 0x10;
  - required: sb ack after 3 cycles; rdata=0xDEAD55EF.
- Sub-word loads:
  - stimulus: with word 0x10 = 0xDEAD55EF, lh 0x12, then lb 0x13;
  - required: rdata=0x0000DEAD, then rdata=0x000000DE.
- Errors:
  - stimulus: lw 0x12, sh 0x11, lb 0x100;
  - required: each gives ack after 1 cycle with err=1 and rdata=0; array contents unchanged.
- Back-to-back: hold req high across two reads of 0x10 and 0x14; required: ack pulses separated by exactly 2 cycles (ack, IDLE, FETCH, ack).
- Reset mid-write:
  - stimulus: sb 0xAA to 0x20 (word 0x20 preloaded with 0x11223344); assert reset during the FETCH cycle;
  - required: no ack; ack=0, err=0 and rdata=0 during reset; a later lw 0x20 returns 0x11223344.
